alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Upstream issue stage for the 4-bit ALU. It buffers incoming register-to-register instructions in a 2-entry queue and holds a 4-entry × 4-bit register file. It drives registered select/operand lines into the combinational ALU, captures the ALU result one cycle later and writes it back to the register file. Each retired instruction is reported on a one-cycle result strobe. It is the block that feeds the ALU's `s`, `a` and `b` inputs and consumes its `o` output.

## Interface
- `DATA_W`, 4: operand/result width; equals the ALU width.
- `NREGS`, 4: register-file entries; register index width is 2.
- `QDEPTH`, 2: instruction queue depth.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  queue can accept; equals `!rst && count < QDEPTH`.
- `in_instr`  in  10  `{op[9:6], rd[5:4], ra[3:2], rb[1:0]}`.
- `stall`  in  1  while high, no issue from the queue.
- `wr_en`  in  1  host register write.
- `wr_addr`  in  2  host write index.
- `wr_data`  in  4  host write data.
- `alu_s`  out  4  registered ALU select.
- `alu_a`  out  4  registered ALU operand A.
- `alu_b`  out  4  registered ALU operand B.
- `alu_o`  in  4  ALU combinational result.
- `res_valid`  out  1  one-cycle retire strobe.
- `res_rd`  out  2  destination of retired instruction.
- `res_data`  out  4  retired result.
- `res_zero`  out  1  `res_data == 0`.

## Operation
- **Accept.** A push occurs on a rising edge with `in_valid && in_ready`. The queue is FIFO-ordered. There is no push-through when full: `in_ready` depends only on the count.
- **Issue.**
  - Issue occurs on an edge when the queue is non-empty and `stall` is 0. It pops the head and loads `alu_s=op`, `alu_a=R[ra]`, `alu_b=R[rb]`, sets `ex_valid=1` and `ex_rd=rd`.
  - Otherwise `ex_valid` clears. `alu_s`/`alu_a`/`alu_b` hold their last values.
- **Operand read priority.** EX-stage forward beats register-file contents.
  - If `ex_valid && ex_rd==ra`, then `alu_a` takes `alu_o`. The same rule applies to `rb` and `alu_b`.
  - A host write in the same cycle is not bypassed to operand reads.
- **Writeback.** On an edge with `ex_valid`: `R[ex_rd] <= alu_o`, `res_valid <= 1`, `res_rd <= ex_rd`, `res_data <= alu_o`, `res_zero <= (alu_o==0)`. Otherwise `res_valid <= 0` and the other `res_*` outputs hold.
- **Host write.** `R[wr_addr] <= wr_data`. On a same-edge collision with a writeback to the same index, the host write wins. `res_*` still reports the ALU value.
- **Arithmetic.** The ALU owns all arithmetic; results wrap modulo 16. This block performs no arithmetic on data.
- **Stall.** Stall blocks issue only. An instruction already in EX retires normally. Pushes continue until the queue is full.

## Timing
- **Reset** (synchronous, while `rst` high, at the edge):
  - R[0..3]=0, queue empty, `ex_valid=0`.
  - `alu_s/a/b=0`, `res_valid=0`, `res_rd=0`, `res_data=0`, `res_zero=0`.
  - `in_ready=0` while `rst` is high.
  - Reset mid-operation discards queued and in-flight instructions with no `res_valid`.
- **Latency** (empty queue, no stall):
  - Push at edge E0 → issue at E1 (`alu_*` valid during cycle E1) → writeback at E2.
  - `res_valid` is high for exactly the cycle after E2.
- **Throughput.** One issue and one retire per cycle sustained. Back-to-back dependent instructions incur no bubble, via forwarding.
- **Simultaneous events.** Push and pop on the same edge leave the count unchanged. A push into an empty queue is not issued on that same edge.

## Structure
- Shared package `alu_issue_pkg`:
  - `DATA_W`, `NREGS`, `QDEPTH`.
  - Instruction field offsets.
  - Opcode constants matching the ALU select encoding (0000 add, 0001 add+1, 0010 sub, 0101 inc, 1000 and, 1110 shr, ...).
- One natural sub-module: `instr_fifo`, a parameterised synchronous FIFO (push/pop/count/full/empty).
- Register file, issue and writeback logic live in the top level.
- The ALU is instantiated beside this block, not inside it.

## Test plan
- Host write R1=3, R2=5, then push add (op 0000, rd0, ra1, rb2) → `alu_s=0000`, `alu_a=3`, `alu_b=5` one cycle after accept; `res_valid`, `res_rd=0`, `res_data=8`, `res_zero=0` two cycles after accept.
- Back-to-back: add R3=R1+R2, then sub (0010) R0=R3−R2 → second issue has `alu_a=8` (forwarded), `alu_b=5`; results 8, then 3 on consecutive cycles.
- Wrap and zero: R1=F, inc (0101) rd1, ra1 → `res_data=0`, `res_zero=1`, R1 reads 0 afterwards.
- Queue full: `stall=1`, push two instructions → `in_ready=0`, third held. Drop `stall` → in-order retire on consecutive cycles; third accepted after the first pop.
- Collision: host write R0=A on the same edge as writeback of 8 to R0 → `res_data=8`, R0=A afterwards.
- Reset while two queued and one in EX → no `res_valid` follows; all outputs 0; R0..R3=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared widths, instruction layout and ALU select encodings for the ALU issue stage.
package alu_issue_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned NREGS   = 4;
    localparam int unsigned QDEPTH  = 2;
    localparam int unsigned REG_W   = $clog2(NREGS);
    localparam int unsigned OP_W    = 4;
    localparam int unsigned INSTR_W = OP_W + 3 * REG_W;

    localparam int unsigned OP_LSB = 6;
    localparam int unsigned RD_LSB = 4;
    localparam int unsigned RA_LSB = 2;
    localparam int unsigned RB_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_ADDC = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_INC  = 4'b0101,
        OP_AND  = 4'b1000,
        OP_SHR  = 4'b1110
    } alu_op_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op = raw[OP_LSB +: OP_W];
        d.rd = raw[RD_LSB +: REG_W];
        d.ra = raw[RA_LSB +: REG_W];
        d.rb = raw[RB_LSB +: REG_W];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// Parameterised synchronous FIFO; pushes when full and pops when empty are ignored.
module instr_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 4-bit ALU: instruction queue, register file, operand
// forwarding from EX, and result writeback with a one-cycle retire strobe.
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               stall,
    input  logic               wr_en,
    input  logic [REG_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [OP_W-1:0]    alu_s,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_o,
    output logic               res_valid,
    output logic [REG_W-1:0]   res_rd,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_zero
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [INSTR_W-1:0] q_dout;
    logic [CNT_W-1:0]   q_count;
    logic               q_empty, unused_q_full;
    logic               push, issue;
    instr_t             head;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              ex_valid_q, ex_valid_d;
    logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
    logic [OP_W-1:0]   alu_s_q, alu_s_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              res_valid_q, res_valid_d, res_zero_q, res_zero_d;
    logic [REG_W-1:0]  res_rd_q, res_rd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    instr_fifo #(
        .WIDTH(INSTR_W),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (issue),
        .din  (in_instr),
        .dout (q_dout),
        .count(q_count),
        .full (unused_q_full),
        .empty(q_empty)
    );

    assign in_ready = !rst && (q_count < CNT_W'(QDEPTH));
    assign push     = in_valid && in_ready;
    assign issue    = !q_empty && !stall;
    assign head     = decode(q_dout);

    always_comb begin
        alu_s_d    = alu_s_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        ex_valid_d = issue;
        ex_rd_d    = ex_rd_q;
        if (issue) begin
            alu_s_d = head.op;
            ex_rd_d = head.rd;
            // The EX result beats the register file so dependent ops issue back to back.
            alu_a_d = (ex_valid_q && ex_rd_q == head.ra) ? alu_o : regs_q[head.ra];
            alu_b_d = (ex_valid_q && ex_rd_q == head.rb) ? alu_o : regs_q[head.rb];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        res_valid_d = ex_valid_q;
        res_rd_d    = res_rd_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        if (ex_valid_q) begin
            regs_d[ex_rd_q] = alu_o;
            res_rd_d        = ex_rd_q;
            res_data_d      = alu_o;
            res_zero_d      = (alu_o == '0);
        end
        // Host write is applied last so it wins a same-index collision.
        if (wr_en) regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            alu_s_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            alu_s_q     <= alu_s_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign alu_s     = alu_s_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_rd    = res_rd_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;

endmodule
